// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and an optional
// second skid entry. Control bits are masked whenever the head entry is not valid.
module pipe_stage_reg #(
  parameter int TAG_W  = 64,
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  mainTag_q, mainTag_d, skidTag_q, skidTag_d;
  logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d, skidCtrl_q, skidCtrl_d;
  logic [DATA_W-1:0] mainData_q, mainData_d, skidData_q, skidData_d;
  logic              push, pop;

  // Without a skid entry the stage can only accept when the head leaves this cycle;
  // with one, readiness depends only on the registered state.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID == 0) ? (~out_valid | out_ready) : (state_q != TWO);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_tag   = mainTag_q;
  assign out_data  = mainData_q;
  assign out_ctrl  = mainCtrl_q & {CTRL_W{out_valid}};
  assign occupancy = state_q;

  always_comb begin
    state_d    = state_q;
    mainTag_d  = mainTag_q;
    mainCtrl_d = mainCtrl_q;
    mainData_d = mainData_q;
    skidTag_d  = skidTag_q;
    skidCtrl_d = skidCtrl_q;
    skidData_d = skidData_q;
    if (flush) begin
      state_d    = EMPTY;
      mainCtrl_d = '0;
      skidCtrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d    = ONE;
            mainTag_d  = in_tag;
            mainCtrl_d = in_ctrl;
            mainData_d = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            mainTag_d  = in_tag;
            mainCtrl_d = in_ctrl;
            mainData_d = in_data;
          end else if (push && (SKID != 0)) begin
            // Head is stalled, so the newcomer parks in the skid entry.
            state_d    = TWO;
            skidTag_d  = in_tag;
            skidCtrl_d = in_ctrl;
            skidData_d = in_data;
          end else if (pop) begin
            state_d    = EMPTY;
            mainCtrl_d = '0;
          end
        end
        TWO: begin
          if (pop) begin
            state_d    = ONE;
            mainTag_d  = skidTag_q;
            mainCtrl_d = skidCtrl_q;
            mainData_d = skidData_q;
            skidCtrl_d = '0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      mainTag_q  <= '0;
      mainCtrl_q <= '0;
      mainData_q <= '0;
      skidTag_q  <= '0;
      skidCtrl_q <= '0;
      skidData_q <= '0;
    end else begin
      state_q    <= state_d;
      mainTag_q  <= mainTag_d;
      mainCtrl_q <= mainCtrl_d;
      mainData_q <= mainData_d;
      skidTag_q  <= skidTag_d;
      skidCtrl_q <= skidCtrl_d;
      skidData_q <= skidData_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives identical stimulus into a SKID=0 and a SKID=1 instance and checks both
// against a simple FIFO model of capacity 1 and 2 respectively.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        inValid;
  logic        outReady;
  logic [63:0] inTag;
  logic [7:0]  inCtrl;
  logic [95:0] inData;

  logic        inReady   [2];
  logic        outValid  [2];
  logic [63:0] outTag    [2];
  logic [7:0]  outCtrl   [2];
  logic [95:0] outData   [2];
  logic [1:0]  occupancy [2];

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [63:0] tag;
    logic [7:0]  ctrl;
    logic [95:0] data;
  } item_t;

  item_t mem [2][2];
  int    cnt [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(.TAG_W(64), .CTRL_W(8), .DATA_W(96), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(inReady[0]),
    .in_tag(inTag), .in_ctrl(inCtrl), .in_data(inData),
    .out_valid(outValid[0]), .out_ready(outReady),
    .out_tag(outTag[0]), .out_ctrl(outCtrl[0]), .out_data(outData[0]),
    .occupancy(occupancy[0])
  );

  pipe_stage_reg #(.TAG_W(64), .CTRL_W(8), .DATA_W(96), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(inReady[1]),
    .in_tag(inTag), .in_ctrl(inCtrl), .in_data(inData),
    .out_valid(outValid[1]), .out_ready(outReady),
    .out_tag(outTag[1]), .out_ctrl(outCtrl[1]), .out_data(outData[1]),
    .occupancy(occupancy[1])
  );

  task automatic checkOutput(input string name, input int s,
                             input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s skid%0d: got %0h, expected %0h", name, s, act, exp);
    end
  endtask

  // Compares every visible output of instance s with the head of its model FIFO.
  task automatic checkModel(input int s);
    checkOutput("out_valid", s, 128'(outValid[s]), 128'(cnt[s] > 0));
    checkOutput("occupancy", s, 128'(occupancy[s]), 128'(cnt[s]));
    checkOutput("out_ctrl", s, 128'(outCtrl[s]), (cnt[s] > 0) ? 128'(mem[s][0].ctrl) : 128'(0));
    if (cnt[s] > 0) begin
      checkOutput("out_tag", s, 128'(outTag[s]), 128'(mem[s][0].tag));
      checkOutput("out_data", s, 128'(outData[s]), 128'(mem[s][0].data));
    end
  endtask

  // Entered and left at a negedge: drive, check readiness, advance model, clock, check.
  task automatic applyStimulus(input logic v, input logic r, input logic f,
                               input logic [63:0] t, input logic [7:0] c,
                               input logic [95:0] d);
    logic expRdy;
    inValid = v; outReady = r; flush = f; inTag = t; inCtrl = c; inData = d;
    #1;
    for (int s = 0; s < 2; s++) begin
      expRdy = (s == 0) ? ((cnt[s] == 0) || r) : (cnt[s] < 2);
      checkOutput("in_ready", s, 128'(inReady[s]), 128'(expRdy));
      if (f) begin
        cnt[s] = 0;
      end else begin
        if (cnt[s] > 0 && r) begin
          mem[s][0] = mem[s][1];
          cnt[s]--;
        end
        if (v && expRdy) begin
          mem[s][cnt[s]] = '{tag: t, ctrl: c, data: d};
          cnt[s]++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) checkModel(s);
  endtask

  typedef struct {
    logic       v;
    logic       r;
    logic [7:0] tag;
    logic [7:0] ctrl;
    logic       expValid;
    logic [7:0] expTag;
    logic [7:0] expCtrl;
    logic [1:0] expOcc;
  } vec_t;

  vec_t vecs [11];

  initial begin
    // Stream 1..5 (tag 5 carries all-ones ctrl), a bubble, 6..8, then drain.
    for (int i = 0; i < 5; i++)
      vecs[i] = '{1'b1, 1'b1, 8'(i + 1), (i == 4) ? 8'hFF : 8'(3 * (i + 1)),
                  1'b1, 8'(i + 1), (i == 4) ? 8'hFF : 8'(3 * (i + 1)), 2'd1};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 2'd0};
    for (int i = 6; i < 9; i++)
      vecs[i] = '{1'b1, 1'b1, 8'(i), 8'(3 * i), 1'b1, 8'(i), 8'(3 * i), 2'd1};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 2'd0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 2'd0};

    cnt[0] = 0; cnt[1] = 0;
    rst_n = 1'b0; flush = 1'b0; inValid = 1'b1; outReady = 1'b1;
    inTag = 64'h77; inCtrl = 8'hFF; inData = 96'h1234;

    // Reset holds everything empty even with traffic offered.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) checkModel(s);
    end
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].r, 1'b0, 64'(vecs[i].tag), vecs[i].ctrl,
                    {88'h0, vecs[i].tag});
      for (int s = 0; s < 2; s++) begin
        checkOutput("vec_valid", s, 128'(outValid[s]), 128'(vecs[i].expValid));
        checkOutput("vec_ctrl", s, 128'(outCtrl[s]), 128'(vecs[i].expCtrl));
        checkOutput("vec_occ", s, 128'(occupancy[s]), 128'(vecs[i].expOcc));
        if (vecs[i].expValid)
          checkOutput("vec_tag", s, 128'(outTag[s]), 128'(vecs[i].expTag));
      end
    end

    // Stall with skid fill, then flush with a simultaneous push that must vanish.
    applyStimulus(1'b1, 1'b0, 1'b0, 64'hA, 8'h11, 96'hA0);
    checkOutput("stall_tagA", 1, 128'(outTag[1]), 128'h0A);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'hB, 8'h22, 96'hB0);
    checkOutput("stall_occ2", 1, 128'(occupancy[1]), 128'd2);
    checkOutput("stall_rdy0", 1, 128'(inReady[1]), 128'd0);
    checkOutput("stall_hold", 1, 128'(outTag[1]), 128'h0A);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 96'h0);
    checkOutput("stall_hold2", 1, 128'(outTag[1]), 128'h0A);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hC, 8'h33, 96'hC0);
    for (int s = 0; s < 2; s++) begin
      checkOutput("flush_valid", s, 128'(outValid[s]), 128'd0);
      checkOutput("flush_ctrl", s, 128'(outCtrl[s]), 128'd0);
      checkOutput("flush_occ", s, 128'(occupancy[s]), 128'd0);
    end
    checkOutput("flush_rdy", 1, 128'(inReady[1]), 128'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 8'h00, 96'h0);
    checkOutput("flush_noC", 1, 128'(outValid[1]), 128'd0);

    // Release after a full skid: A leaves, then B, readiness returns after A.
    applyStimulus(1'b1, 1'b0, 1'b0, 64'hA, 8'h11, 96'hA0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'hB, 8'h22, 96'hB0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 8'h00, 96'h0);
    checkOutput("release_tagB", 1, 128'(outTag[1]), 128'h0B);
    checkOutput("release_rdy", 1, 128'(inReady[1]), 128'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 8'h00, 96'h0);
    checkOutput("release_empty", 1, 128'(outValid[1]), 128'd0);

    // Random traffic against the FIFO model.
    for (int k = 0; k < 10000; k++)
      applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 50) == 0,
                    {$urandom, $urandom}, 8'($urandom),
                    {$urandom, $urandom, $urandom});

    // Asynchronous reset in the middle of held traffic drops everything at once.
    applyStimulus(1'b1, 1'b0, 1'b0, 64'hD, 8'h44, 96'hD0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'hE, 8'h55, 96'hE0);
    rst_n = 1'b0;
    inValid = 1'b0;
    cnt[0] = 0; cnt[1] = 0;
    #1;
    for (int s = 0; s < 2; s++) checkModel(s);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) checkModel(s);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 8'h00, 96'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
